// File: rtl/mgmt_qspi_bridge_pkg.sv
// Shared types and constants for the QSPI to management-bus bridge.
// The address helper wraps inside the 15-bit management address space.
package mgmt_qspi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    WR_DATA,
    RD_DUMMY,
    RD_DATA
  } qspi_state_t;

  localparam int QSPI_READ_FLAG_BIT = 15;
  localparam int HEADER_NIBBLES     = 4;

  function automatic logic [14:0] addr_inc(input logic [14:0] a);
    return a + 15'd1;
  endfunction

endpackage

// File: rtl/mgmt_qspi_input_sync.sv
// Synchroniser chains for SCK, CS_N and DQ, plus edge detection.
// The CS_N chain resets low so a reset taken mid-frame never fakes a CS_N fall.
module mgmt_qspi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       cs_n,
  input  logic [3:0] dq,
  output logic [3:0] dq_s,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic       cs_fall,
  output logic       cs_rise
);

  logic [SYNC_STAGES-1:0]      sck_q;
  logic [SYNC_STAGES-1:0]      cs_q;
  logic [SYNC_STAGES-1:0][3:0] dq_q;
  logic                        sck_d;
  logic                        cs_d;
  logic                        sck_s;
  logic                        cs_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q <= '0;
      cs_q  <= '0;
      dq_q  <= '0;
      sck_d <= 1'b0;
      cs_d  <= 1'b0;
    end else begin
      sck_q <= {sck_q[SYNC_STAGES-2:0], sck};
      cs_q  <= {cs_q[SYNC_STAGES-2:0], cs_n};
      dq_q  <= {dq_q[SYNC_STAGES-2:0], dq};
      sck_d <= sck_s;
      cs_d  <= cs_s;
    end
  end

  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign cs_s     = cs_q[SYNC_STAGES-1];
  assign dq_s     = dq_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d & ~cs_s;
  assign sck_fall = ~sck_s & sck_d & ~cs_s;
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;

endmodule

// File: rtl/mgmt_qspi_bridge.sv
// Quad-SPI slave bridging MCU frames onto the byte-wide management bus.
// SCK is oversampled in clk; reads are prefetched one byte ahead.
module mgmt_qspi_bridge
  import mgmt_qspi_bridge_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DUMMY_CLOCKS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        qspi_sck,
  input  logic        qspi_cs_n,
  input  logic [3:0]  qspi_dq_in,
  output logic [3:0]  qspi_dq_out,
  output logic        qspi_dq_oe,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        underrun
);

  localparam int DW = $clog2(DUMMY_CLOCKS + 1);

  qspi_state_t   state, state_nx;
  logic [3:0]    dq_s;
  logic          sck_rise, sck_fall, cs_fall, cs_rise;
  logic [1:0]    nib_cnt;
  logic          nib_odd;
  logic [11:0]   hdr;
  logic [15:0]   hdr_word;
  logic          hdr_last;
  logic          is_rd;
  logic [DW-1:0] dum_cnt;
  logic          dum_last;
  logic [14:0]   addr;
  logic [3:0]    wr_hi;
  logic [3:0]    lo_nib;
  logic [7:0]    pf_data;
  logic          pf_valid;

  mgmt_qspi_input_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .sck     (qspi_sck),
    .cs_n    (qspi_cs_n),
    .dq      (qspi_dq_in),
    .dq_s    (dq_s),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall),
    .cs_fall (cs_fall),
    .cs_rise (cs_rise)
  );

  assign hdr_word = {hdr, dq_s};
  assign is_rd    = hdr_word[QSPI_READ_FLAG_BIT];
  assign hdr_last = sck_rise && (state == HEADER) &&
                    (nib_cnt == 2'(HEADER_NIBBLES - 1));
  assign dum_last = sck_rise && (state == RD_DUMMY) &&
                    (dum_cnt == DW'(DUMMY_CLOCKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cs_rise) begin
      state_nx = IDLE;
    end else if (cs_fall) begin
      state_nx = HEADER;
    end else begin
      unique case (state)
        HEADER:   if (hdr_last) state_nx = is_rd ? RD_DUMMY : WR_DATA;
        RD_DUMMY: if (dum_last) state_nx = RD_DATA;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_cnt     <= '0;
      nib_odd     <= 1'b0;
      hdr         <= '0;
      dum_cnt     <= '0;
      addr        <= '0;
      wr_hi       <= '0;
      lo_nib      <= '0;
      pf_data     <= '0;
      pf_valid    <= 1'b0;
      qspi_dq_out <= '0;
      qspi_dq_oe  <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      underrun    <= 1'b0;
    end else begin
      rd_en    <= 1'b0;
      wr_en    <= 1'b0;
      underrun <= 1'b0;
      if (cs_rise || cs_fall) begin
        nib_cnt     <= '0;
        nib_odd     <= 1'b0;
        dum_cnt     <= '0;
        pf_valid    <= 1'b0;
        qspi_dq_oe  <= 1'b0;
        qspi_dq_out <= '0;
      end else begin
        unique case (state)
          HEADER: begin
            if (sck_rise) begin
              hdr     <= {hdr[7:0], dq_s};
              nib_cnt <= nib_cnt + 2'd1;
            end
            if (hdr_last && is_rd) begin
              rd_en   <= 1'b1;
              rd_addr <= {1'b0, hdr_word[14:0]};
              addr    <= addr_inc(hdr_word[14:0]);
            end else if (hdr_last) begin
              addr <= hdr_word[14:0];
            end
          end
          WR_DATA: begin
            if (sck_rise) begin
              nib_odd <= ~nib_odd;
              if (!nib_odd) begin
                wr_hi <= dq_s;
              end else begin
                wr_en   <= 1'b1;
                wr_addr <= {1'b0, addr};
                wr_data <= {wr_hi, dq_s};
                addr    <= addr_inc(addr);
              end
            end
          end
          RD_DUMMY: begin
            if (sck_rise) dum_cnt <= dum_cnt + DW'(1);
          end
          RD_DATA: begin
            if (sck_fall) begin
              nib_odd <= ~nib_odd;
              if (!nib_odd) begin
                // Empty prefetch sends a zero byte but still fetches ahead
                lo_nib      <= pf_valid ? pf_data[3:0] : 4'h0;
                qspi_dq_out <= pf_valid ? pf_data[7:4] : 4'h0;
                qspi_dq_oe  <= 1'b1;
                pf_valid    <= 1'b0;
                underrun    <= ~pf_valid;
                rd_en       <= 1'b1;
                rd_addr     <= {1'b0, addr};
                addr        <= addr_inc(addr);
              end else begin
                qspi_dq_out <= lo_nib;
              end
            end
          end
          default: ;
        endcase
        if (rd_valid && (state == RD_DUMMY || state == RD_DATA)) begin
          pf_data  <= rd_data;
          pf_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mgmt_qspi_bridge.sv
// Bench: an MCU-side QSPI driver and a register-bus responder with memory,
// comparing bus strobes and returned bytes against frame-level expectations.
module tb_mgmt_qspi_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        qspi_sck = 1'b0;
  logic        qspi_cs_n = 1'b1;
  logic [3:0]  qspi_dq_in = 4'h0;
  logic [3:0]  qspi_dq_out;
  logic        qspi_dq_oe;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic        rd_valid = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        underrun;

  mgmt_qspi_bridge #(
    .SYNC_STAGES (2),
    .DUMMY_CLOCKS(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .qspi_sck   (qspi_sck),
    .qspi_cs_n  (qspi_cs_n),
    .qspi_dq_in (qspi_dq_in),
    .qspi_dq_out(qspi_dq_out),
    .qspi_dq_oe (qspi_dq_oe),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [14:0] a;
  } req_t;

  logic [7:0]  mem [32768];
  req_t        rq[$];
  logic [15:0] wr_a_q[$];
  logic [7:0]  wr_d_q[$];
  logic [15:0] rd_a_q[$];
  int          urun_cnt = 0;
  int          both_cnt = 0;
  int          cyc = 0;
  int          last_due = 0;
  bit          slow_en = 1'b0;
  logic [14:0] slow_addr = '0;
  int          half = 5;
  logic [7:0]  wbytes[$];
  logic [7:0]  rbytes[$];

  // Register-bus responder and strobe logger
  initial begin
    int d, due;
    forever begin
      @(negedge clk);
      cyc++;
      rd_valid = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        rd_valid = 1'b1;
        rd_data  = mem[rq[0].a];
        void'(rq.pop_front());
      end
      if (rd_en) begin
        rd_a_q.push_back(rd_addr);
        d   = (slow_en && rd_addr[14:0] == slow_addr) ? 39 : 1;
        due = cyc + d;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rq.push_back('{due: due, a: rd_addr[14:0]});
      end
      if (wr_en) begin
        wr_a_q.push_back(wr_addr);
        wr_d_q.push_back(wr_data);
      end
      if (underrun) urun_cnt++;
      if (rd_en && wr_en) both_cnt++;
    end
  end

  task automatic tk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sck_cyc(input logic [3:0] o, output logic [3:0] i);
    qspi_sck   = 1'b0;
    qspi_dq_in = o;
    tk(half);
    i = qspi_dq_out;
    qspi_sck = 1'b1;
    tk(half);
  endtask

  task automatic xfer(input bit is_rd, input logic [14:0] a,
                      input int n, input int extra);
    logic [15:0] h;
    logic [3:0]  x, hi;
    logic [7:0]  b8;
    h = {is_rd, a};
    qspi_cs_n = 1'b0;
    tk(half);
    for (int k = 3; k >= 0; k--) sck_cyc(h[k*4+:4], x);
    rbytes.delete();
    if (is_rd) begin
      for (int k = 0; k < 4; k++) sck_cyc(4'($urandom), x);
      for (int b = 0; b < n; b++) begin
        sck_cyc(4'($urandom), hi);
        sck_cyc(4'($urandom), x);
        rbytes.push_back({hi, x});
      end
      check("oe_on", qspi_dq_oe, 1);
    end else begin
      for (int b = 0; b < n; b++) begin
        b8 = wbytes[b];
        sck_cyc(b8[7:4], x);
        sck_cyc(b8[3:0], x);
      end
      for (int e = 0; e < extra; e++) sck_cyc(4'($urandom), x);
    end
    qspi_cs_n = 1'b1;
    tk(2);
    qspi_sck = 1'b0;
    tk(2);
    check("oe_off", qspi_dq_oe, 0);
    tk(6);
  endtask

  task automatic do_write(input logic [14:0] a, input int extra);
    int bw, br, n;
    bw = wr_a_q.size();
    br = rd_a_q.size();
    n  = wbytes.size();
    xfer(1'b0, a, n, extra);
    check("wr_cnt", wr_a_q.size() - bw, n);
    for (int i = 0; i < n; i++) begin
      if (bw + i < wr_a_q.size()) begin
        check("wr_addr", wr_a_q[bw+i], {1'b0, 15'(a + i)});
        check("wr_data", wr_d_q[bw+i], wbytes[i]);
      end
    end
    check("wr_no_rd", rd_a_q.size() - br, 0);
  endtask

  task automatic do_read(input logic [14:0] a, input int n, input bit slow);
    int bw, br, bu;
    logic [7:0] exp;
    bw = wr_a_q.size();
    br = rd_a_q.size();
    bu = urun_cnt;
    xfer(1'b1, a, n, 0);
    check("rd_cnt", rd_a_q.size() - br, n + 1);
    for (int i = 0; i <= n; i++) begin
      if (br + i < rd_a_q.size())
        check("rd_addr", rd_a_q[br+i], {1'b0, 15'(a + i)});
    end
    for (int b = 0; b < n; b++) begin
      exp = (slow && b == 0) ? 8'h00 : mem[15'(a + b)];
      check("rd_byte", rbytes[b], exp);
    end
    check("urun", urun_cnt - bu, slow ? 1 : 0);
    check("rd_no_wr", wr_a_q.size() - bw, 0);
  endtask

  function automatic logic [63:0] outs();
    return {qspi_dq_out, qspi_dq_oe, rd_en, rd_addr, wr_en,
            wr_addr, wr_data, underrun};
  endfunction

  initial begin
    logic [3:0] x;
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    mem[16'h0060] = 8'h01;
    mem[16'h1000] = 8'hAA;
    mem[16'h1001] = 8'hBB;
    mem[16'h1002] = 8'hCC;

    tk(3);
    check("rst_outs", outs(), 64'd0);
    rst_n = 1'b1;
    tk(4);

    wbytes = '{8'h34, 8'h12};
    do_write(15'h0084, 0);
    do_read(15'h0060, 1, 1'b0);
    do_read(15'h1000, 3, 1'b0);

    wbytes.delete();
    do_write(15'h0028, 1);
    wbytes = '{8'h5A};
    do_write(15'h0028, 0);

    half = 4;
    slow_en = 1'b1;
    slow_addr = 15'h7FFF;
    do_read(15'h7FFF, 2, 1'b1);
    slow_en = 1'b0;

    for (int t = 0; t < 12; t++) begin
      logic [14:0] a;
      int n;
      half = $urandom_range(4, 7);
      a = 15'($urandom);
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        do_read(a, n, 1'b0);
      end else begin
        wbytes.delete();
        for (int i = 0; i < n; i++) wbytes.push_back(8'($urandom));
        do_write(a, $urandom_range(0, 1));
      end
    end

    half = 5;
    qspi_cs_n = 1'b0;
    tk(half);
    for (int k = 3; k >= 0; k--) begin
      logic [15:0] h;
      h = 16'h8100;
      sck_cyc(h[k*4+:4], x);
    end
    for (int k = 0; k < 7; k++) sck_cyc(4'h0, x);
    check("mid_oe", qspi_dq_oe, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst", outs(), 64'd0);
    tk(2);
    qspi_cs_n = 1'b1;
    qspi_sck  = 1'b0;
    tk(2);
    rst_n = 1'b1;
    tk(6);
    wbytes = '{8'hC3};
    do_write(15'h002C, 0);

    check("excl", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
